// File: rtl/morty_ex_pkg.sv
// Shared opcode and FSM definitions for the morty execute unit and its decode stage.
package morty_ex_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OPC_ADD    = 5'd0;
  localparam logic [OP_W-1:0] OPC_SLL    = 5'd1;
  localparam logic [OP_W-1:0] OPC_SUB    = 5'd2;
  localparam logic [OP_W-1:0] OPC_SRA    = 5'd3;
  localparam logic [OP_W-1:0] OPC_XOR    = 5'd4;
  localparam logic [OP_W-1:0] OPC_SRL    = 5'd5;
  localparam logic [OP_W-1:0] OPC_OR     = 5'd6;
  localparam logic [OP_W-1:0] OPC_AND    = 5'd7;
  localparam logic [OP_W-1:0] OPC_SLT    = 5'd8;
  localparam logic [OP_W-1:0] OPC_SLTU   = 5'd9;
  localparam logic [OP_W-1:0] OPC_MUL    = 5'd10;
  localparam logic [OP_W-1:0] OPC_MULH   = 5'd11;
  localparam logic [OP_W-1:0] OPC_MULHSU = 5'd12;
  localparam logic [OP_W-1:0] OPC_MULHU  = 5'd13;
  localparam logic [OP_W-1:0] OPC_DIV    = 5'd14;
  localparam logic [OP_W-1:0] OPC_DIVU   = 5'd15;
  localparam logic [OP_W-1:0] OPC_REM    = 5'd16;
  localparam logic [OP_W-1:0] OPC_REMU   = 5'd17;

  // Codes 18..31 are left unnamed; they decode to a zero result.
  typedef enum logic [OP_W-1:0] {
    OP_ADD    = OPC_ADD,
    OP_SLL    = OPC_SLL,
    OP_SUB    = OPC_SUB,
    OP_SRA    = OPC_SRA,
    OP_XOR    = OPC_XOR,
    OP_SRL    = OPC_SRL,
    OP_OR     = OPC_OR,
    OP_AND    = OPC_AND,
    OP_SLT    = OPC_SLT,
    OP_SLTU   = OPC_SLTU,
    OP_MUL    = OPC_MUL,
    OP_MULH   = OPC_MULH,
    OP_MULHSU = OPC_MULHSU,
    OP_MULHU  = OPC_MULHU,
    OP_DIV    = OPC_DIV,
    OP_DIVU   = OPC_DIVU,
    OP_REM    = OPC_REM,
    OP_REMU   = OPC_REMU
  } ex_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  function automatic logic is_mul_op(input ex_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div_op(input ex_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic div_is_signed(input ex_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic div_is_rem(input ex_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/morty_div_iter.sv
// Restoring radix-2 divider on operand magnitudes, one quotient bit per clock.
// Zero-divisor and signed-overflow cases are flagged combinationally so the caller can skip iteration.
module morty_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic            is_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            special,
  output logic [XLEN-1:0] special_quo,
  output logic [XLEN-1:0] special_rem,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]   cnt_q;
  logic            active_q, neg_quo_q, neg_rem_q;

  logic            a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] a_mag, b_mag, rem_n, quo_n;
  logic [XLEN:0]   trial, diff;

  assign a_neg = is_signed & a[XLEN-1];
  assign b_neg = is_signed & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign div_zero    = (b == '0);
  assign overflow    = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign special     = div_zero | overflow;
  assign special_quo = div_zero ? '1 : a;
  assign special_rem = div_zero ? a : '0;

  // Shift the next dividend bit into the partial remainder and try the subtraction.
  assign trial = {rem_q, quo_q[XLEN-1]};
  assign diff  = trial - {1'b0, dvs_q};
  assign rem_n = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_n = {quo_q[XLEN-2:0], ~diff[XLEN]};

  // The final step's results leave combinationally with signs applied, so the
  // caller captures them on the same edge the last bit is produced.
  assign done      = active_q && (cnt_q == CW'(1));
  assign quotient  = neg_quo_q ? -quo_n : quo_n;
  assign remainder = neg_rem_q ? -rem_n : rem_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (kill) begin
      active_q <= 1'b0;
    end else if (start) begin
      rem_q     <= '0;
      quo_q     <= a_mag;
      dvs_q     <= b_mag;
      cnt_q     <= CW'(XLEN);
      active_q  <= 1'b1;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end else if (active_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/morty_ex_unit.sv
// Multi-cycle RV32I/M execute unit with valid/ready on both sides and a registered result.
// state   | meaning
// IDLE    | no operation held; ready for a new one
// BUSY    | multiply product or divide iteration in progress
// DONE    | result_o/tag_o valid, held until downstream takes them
module morty_ex_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0]       op_i,
  input  logic [XLEN-1:0]  src_a_i,
  input  logic [XLEN-1:0]  src_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  import morty_ex_pkg::*;

  localparam int SHW = $clog2(XLEN);

  ex_state_e         state_q, state_d;
  ex_op_e            op_in, op_q;
  logic [XLEN-1:0]   result_q, result_d, alu_res;
  logic [TAG_W-1:0]  tag_q;
  logic [2*XLEN-1:0] prod_q, mul_a, mul_b;
  logic [SHW-1:0]    shamt;
  logic              accept, mul_a_sgn, mul_b_sgn;

  logic              div_start, div_special, div_done;
  logic [XLEN-1:0]   div_quo, div_rem, div_spec_quo, div_spec_rem;

  assign op_in  = ex_op_e'(op_i);
  assign shamt  = src_b_i[SHW-1:0];

  // Reset is folded in so every output reads zero while rst_i is held.
  assign ready_o = !rst_i && !flush_i &&
                   ((state_q == ST_IDLE) || ((state_q == ST_DONE) && ready_i));
  assign accept  = valid_i && ready_o;

  assign valid_o  = (state_q == ST_DONE);
  assign busy_o   = (state_q != ST_IDLE);
  assign result_o = result_q;
  assign tag_o    = tag_q;

  always_comb begin
    alu_res = '0;
    case (op_in)
      OP_ADD:  alu_res = src_a_i + src_b_i;
      OP_SLL:  alu_res = src_a_i << shamt;
      OP_SUB:  alu_res = src_a_i - src_b_i;
      OP_SRA:  alu_res = $signed(src_a_i) >>> shamt;
      OP_XOR:  alu_res = src_a_i ^ src_b_i;
      OP_SRL:  alu_res = src_a_i >> shamt;
      OP_OR:   alu_res = src_a_i | src_b_i;
      OP_AND:  alu_res = src_a_i & src_b_i;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a_i) < $signed(src_b_i))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a_i < src_b_i)};
      default: alu_res = '0;
    endcase
  end

  // Extending both operands to 2*XLEN makes one unsigned multiplier cover all four variants.
  assign mul_a_sgn = (op_in == OP_MULH) || (op_in == OP_MULHSU);
  assign mul_b_sgn = (op_in == OP_MULH);
  assign mul_a     = {{XLEN{mul_a_sgn & src_a_i[XLEN-1]}}, src_a_i};
  assign mul_b     = {{XLEN{mul_b_sgn & src_b_i[XLEN-1]}}, src_b_i};

  assign div_start = accept && is_div_op(op_in) && !div_special;

  morty_div_iter #(.XLEN(XLEN)) u_div (
    .clk         (clk_i),
    .rst         (rst_i),
    .start       (div_start),
    .kill        (flush_i),
    .is_signed   (div_is_signed(op_in)),
    .a           (src_a_i),
    .b           (src_b_i),
    .special     (div_special),
    .special_quo (div_spec_quo),
    .special_rem (div_spec_rem),
    .done        (div_done),
    .quotient    (div_quo),
    .remainder   (div_rem)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_BUSY: begin
        if (is_mul_op(op_q)) begin
          state_d  = ST_DONE;
          result_d = (op_q == OP_MUL) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
        end else if (div_done) begin
          state_d  = ST_DONE;
          result_d = div_is_rem(op_q) ? div_rem : div_quo;
        end
      end
      ST_DONE: if (ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      if (is_mul_op(op_in)) begin
        state_d = ST_BUSY;
      end else if (is_div_op(op_in) && !div_special) begin
        state_d = ST_BUSY;
      end else begin
        state_d  = ST_DONE;
        result_d = is_div_op(op_in) ? (div_is_rem(op_in) ? div_spec_rem : div_spec_quo)
                                    : alu_res;
      end
    end

    if (flush_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      tag_q    <= '0;
      op_q     <= OP_ADD;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        tag_q <= tag_i;
        op_q  <= op_in;
      end
      if (accept && is_mul_op(op_in)) prod_q <= mul_a * mul_b;
    end
  end

endmodule
